// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for a shared 10-bit signed ALU (proj1).
// One operation is in flight at a time: IDLE accepts, EXEC evaluates, HOLD presents the response.

// proj1: 10-bit signed ALU. Flags are {N, Z, C, V}.
// C is the adder carry-out; SUB computes a + ~b + 1, so C=1 means no borrow. C and V are 0 for non-arithmetic ops.
module proj1 #(
  parameter int W     = 10,
  parameter int OPW   = 3,
  parameter int FLAGW = 4
) (
  input  logic [W-1:0]     i_arg0,
  input  logic [W-1:0]     i_arg1,
  input  logic [OPW-1:0]   i_oper,
  output logic [W-1:0]     o_result,
  output logic [FLAGW-1:0] o_flag
);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
  localparam logic [OPW-1:0] OP_MAX  = OPW'(2);
  localparam logic [OPW-1:0] OP_MIN  = OPW'(3);
  localparam logic [OPW-1:0] OP_AND  = OPW'(4);
  localparam logic [OPW-1:0] OP_ORR  = OPW'(5);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(6);

  logic [W:0]   sum;
  logic [W:0]   dif;
  logic         a_lt_b;
  logic [W-1:0] res;
  logic         carry;
  logic         ovf;

  assign sum    = {1'b0, i_arg0} + {1'b0, i_arg1};
  assign dif    = {1'b0, i_arg0} + {1'b0, ~i_arg1} + (W+1)'(1);
  assign a_lt_b = $signed(i_arg0) < $signed(i_arg1);

  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (i_oper)
      OP_ADD: begin
        res   = sum[W-1:0];
        carry = sum[W];
        ovf   = (i_arg0[W-1] == i_arg1[W-1]) && (res[W-1] != i_arg0[W-1]);
      end
      OP_SUB: begin
        res   = dif[W-1:0];
        carry = dif[W];
        ovf   = (i_arg0[W-1] != i_arg1[W-1]) && (res[W-1] != i_arg0[W-1]);
      end
      OP_MAX:  res = a_lt_b ? i_arg1 : i_arg0;
      OP_MIN:  res = a_lt_b ? i_arg0 : i_arg1;
      OP_AND:  res = i_arg0 & i_arg1;
      OP_ORR:  res = i_arg0 | i_arg1;
      OP_XOR:  res = i_arg0 ^ i_arg1;
      default: res = ~(i_arg0 ^ i_arg1);
    endcase
  end

  assign o_result = res;
  assign o_flag   = {res[W-1], (res == '0), carry, ovf};
endmodule

// Handshake: a request transfers on the rising edge where reqN_valid && reqN_ready;
// the response transfers on the rising edge where rsp_valid && rsp_ready.
module alu_rr_arbiter #(
  parameter int W     = 10,
  parameter int OPW   = 3,
  parameter int FLAGW = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [W-1:0]     i_req0_arg0,
  input  logic [W-1:0]     i_req0_arg1,
  input  logic [OPW-1:0]   i_req0_oper,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [W-1:0]     i_req1_arg0,
  input  logic [W-1:0]     i_req1_arg1,
  input  logic [OPW-1:0]   i_req1_oper,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic             o_rsp_id,
  output logic [W-1:0]     o_rsp_result,
  output logic [FLAGW-1:0] o_rsp_flag
);
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [W-1:0]     arg0_q, arg0_d;
  logic [W-1:0]     arg1_q, arg1_d;
  logic [OPW-1:0]   oper_q, oper_d;
  logic             id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [W-1:0]     rsp_result_q, rsp_result_d;
  logic [FLAGW-1:0] rsp_flag_q, rsp_flag_d;
  logic [W-1:0]     alu_result;
  logic [FLAGW-1:0] alu_flag;
  logic             grant1;

  proj1 #(.W(W), .OPW(OPW), .FLAGW(FLAGW)) u_alu (
    .i_arg0   (arg0_q),
    .i_arg1   (arg1_q),
    .i_oper   (oper_q),
    .o_result (alu_result),
    .o_flag   (alu_flag)
  );

  // last_q remembers the previous winner (1 = req1); a tie goes to the other side.
  assign grant1 = i_req1_valid & (~i_req0_valid | ~last_q);

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    arg0_d       = arg0_q;
    arg1_d       = arg1_q;
    oper_d       = oper_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flag_d   = rsp_flag_q;
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        o_req0_ready = i_req0_valid & ~grant1;
        o_req1_ready = grant1;
        if (i_req0_valid | i_req1_valid) begin
          arg0_d  = grant1 ? i_req1_arg0 : i_req0_arg0;
          arg1_d  = grant1 ? i_req1_arg1 : i_req0_arg1;
          oper_d  = grant1 ? i_req1_oper : i_req0_oper;
          id_d    = grant1;
          last_d  = grant1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_flag_d   = alu_flag;
        rsp_id_d     = id_q;
        rsp_valid_d  = 1'b1;
        state_d      = HOLD;
      end
      HOLD: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      arg0_q       <= '0;
      arg1_q       <= '0;
      oper_q       <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flag_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      arg0_q       <= arg0_d;
      arg1_q       <= arg1_d;
      oper_q       <= oper_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flag_q   <= rsp_flag_d;
    end
  end

  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_id     = rsp_id_q;
  assign o_rsp_result = rsp_result_q;
  assign o_rsp_flag   = rsp_flag_q;
endmodule
